multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_if.sv | 39 +++
 rtl/instr_counter.sv | 16 +
 rtl/multicycle_controller.sv | 146 ++++++++++++++
 tb/tb_multicycle_controller.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// State enum, opcodes, datapath mux selects and the control bundle.
package riscv_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECR,
      ALUWB,
      BEQ
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   typedef struct packed {
      logic       pcUpdate;
      logic       adrSrc;
      logic       irWrite;
      logic       memWrite;
      logic       regWrite;
      logic       branch;
      logic [1:0] resultSrc;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       instrDone;
      logic       illegal;
   } ctrl_t;

   function automatic logic [1:0] immSrcOf(input logic [6:0] op);
      unique case (1'b1)
         (op == OP_SW):  immSrcOf = IMM_S;
         (op == OP_BEQ): immSrcOf = IMM_B;
         default:        immSrcOf = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decode inputs in, enables and selects out.
// master is the controller side, slave is the datapath side.
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op;
   logic             zero;
   logic             mem_ready;
   logic             PCWrite;
   logic             AdrSrc;
   logic             IRWrite;
   logic             MemWrite;
   logic             RegWrite;
   logic             Branch;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [1:0]       ImmSrc;
   logic             instr_done;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  op, zero, mem_ready,
      output PCWrite, AdrSrc, IRWrite, MemWrite,
      output RegWrite, Branch, ResultSrc, ALUSrcA,
      output ALUSrcB, ALUOp, ImmSrc, instr_done,
      output illegal, retired
   );

   modport slave (
      output op, zero, mem_ready,
      input  PCWrite, AdrSrc, IRWrite, MemWrite,
      input  RegWrite, Branch, ResultSrc, ALUSrcA,
      input  ALUSrcB, ALUOp, ImmSrc, instr_done,
      input  illegal, retired
   );
endinterface

// File: rtl/instr_counter.sv
// Retired-instruction counter: increments on enable, wraps naturally.
module instr_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     count <= '0;
      else if (en) count <= count + 1'b1;
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: FSM sequencing LW/SW/R-type/BEQ
// through the shared datapath, plus a retired-instruction counter.
module multicycle_controller
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   multicycle_controller_if.master bus
);

   state_t           state;
   state_t           nextState;
   ctrl_t            ctrl;
   logic [CNT_W-1:0] retired;
   logic             isLw;
   logic             isSw;
   logic             isR;
   logic             isBeq;

   assign isLw  = (bus.op == OP_LW);
   assign isSw  = (bus.op == OP_SW);
   assign isR   = (bus.op == OP_R);
   assign isBeq = (bus.op == OP_BEQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         FETCH:    if (bus.mem_ready) nextState = DECODE;
         DECODE: begin
            unique case (1'b1)
               isLw, isSw: nextState = MEMADR;
               isR:        nextState = EXECR;
               isBeq:      nextState = BEQ;
               default:    nextState = FETCH;
            endcase
         end
         MEMADR: begin
            unique case (1'b1)
               isLw:    nextState = MEMREAD;
               isSw:    nextState = MEMWRITE;
               default: nextState = FETCH;
            endcase
         end
         MEMREAD:  if (bus.mem_ready) nextState = MEMWB;
         MEMWRITE: if (bus.mem_ready) nextState = FETCH;
         EXECR:    nextState = ALUWB;
         MEMWB,
         ALUWB,
         BEQ:      nextState = FETCH;
         default:  nextState = FETCH;
      endcase
   end

   always_comb begin
      ctrl = '0;
      unique case (state)
         FETCH: begin
            ctrl.aluSrcA   = SRCA_PC;
            ctrl.aluSrcB   = SRCB_FOUR;
            ctrl.aluOp     = ALU_ADD;
            ctrl.resultSrc = RES_ALURESULT;
            ctrl.irWrite   = bus.mem_ready;
            ctrl.pcUpdate  = bus.mem_ready;
         end
         DECODE: begin
            ctrl.aluSrcA = SRCA_OLDPC;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALU_ADD;
            ctrl.illegal = !(isLw || isSw || isR || isBeq);
         end
         MEMADR: begin
            ctrl.aluSrcA = SRCA_RD1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALU_ADD;
         end
         MEMREAD: begin
            ctrl.adrSrc    = 1'b1;
            ctrl.resultSrc = RES_ALUOUT;
         end
         MEMWB: begin
            ctrl.resultSrc = RES_DATA;
            ctrl.regWrite  = 1'b1;
            ctrl.instrDone = 1'b1;
         end
         MEMWRITE: begin
            ctrl.adrSrc    = 1'b1;
            ctrl.resultSrc = RES_ALUOUT;
            ctrl.memWrite  = 1'b1;
            ctrl.instrDone = bus.mem_ready;
         end
         EXECR: begin
            ctrl.aluSrcA = SRCA_RD1;
            ctrl.aluSrcB = SRCB_RD2;
            ctrl.aluOp   = ALU_FUNCT;
         end
         ALUWB: begin
            ctrl.resultSrc = RES_ALUOUT;
            ctrl.regWrite  = 1'b1;
            ctrl.instrDone = 1'b1;
         end
         BEQ: begin
            ctrl.aluSrcA   = SRCA_RD1;
            ctrl.aluSrcB   = SRCB_RD2;
            ctrl.aluOp     = ALU_SUB;
            ctrl.resultSrc = RES_ALUOUT;
            ctrl.branch    = 1'b1;
            ctrl.instrDone = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   // enables are masked by rst so an in-flight write dies with the reset
   assign bus.PCWrite    = !rst &&
                           (ctrl.pcUpdate || (ctrl.branch && bus.zero));
   assign bus.IRWrite    = !rst && ctrl.irWrite;
   assign bus.MemWrite   = !rst && ctrl.memWrite;
   assign bus.RegWrite   = !rst && ctrl.regWrite;
   assign bus.instr_done = !rst && ctrl.instrDone;
   assign bus.illegal    = !rst && ctrl.illegal;
   assign bus.AdrSrc     = ctrl.adrSrc;
   assign bus.Branch     = ctrl.branch;
   assign bus.ResultSrc  = ctrl.resultSrc;
   assign bus.ALUSrcA    = ctrl.aluSrcA;
   assign bus.ALUSrcB    = ctrl.aluSrcB;
   assign bus.ALUOp      = ctrl.aluOp;
   assign bus.ImmSrc     = immSrcOf(bus.op);
   assign bus.retired    = retired;

   instr_counter #(
      .CNT_W(CNT_W)
   ) u_instrCounter (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.instr_done),
      .count(retired)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: driver queues expectations,
// a negedge monitor pops one per instr_done/illegal pulse and compares.
module tb_multicycle_controller;
   import riscv_pkg::*;

   typedef struct {
      bit         ill;
      int         lat;
      int         pcWr;
      int         regWr;
      int         memWr;
      int         br;
      logic [1:0] regRs;
      logic [1:0] brAlu;
      logic [1:0] imm;
      logic [31:0] ret32;
      logic [3:0] ret4;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [6:0] op;
   logic       zero;
   logic       memReady;

   int checks;
   int errors;
   exp_t q[$];
   logic [31:0] m32;
   logic [3:0]  m4;

   multicycle_controller_if #(.CNT_W(32)) bus32 ();
   multicycle_controller_if #(.CNT_W(4))  bus4 ();

   assign bus32.op        = op;
   assign bus32.zero      = zero;
   assign bus32.mem_ready = memReady;
   assign bus4.op         = op;
   assign bus4.zero       = zero;
   assign bus4.mem_ready  = memReady;

   multicycle_controller #(.CNT_W(32)) dut32 (
      .clk(clk),
      .rst(rst),
      .bus(bus32.master)
   );

   multicycle_controller #(.CNT_W(4)) dut4 (
      .clk(clk),
      .rst(rst),
      .bus(bus4.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", n, act, exp);
      end
   endtask

   // drive one instruction; sf = FETCH stall cycles, sm = memory stalls
   task automatic issue(input logic [6:0] o, input logic z,
                        input int sf, input int sm, input bit noise);
      bit   isLw;
      bit   isSw;
      bit   isR;
      bit   isBeq;
      bit   isMem;
      bit   ill;
      int   lat;
      exp_t e;
      isLw  = (o == OP_LW);
      isSw  = (o == OP_SW);
      isR   = (o == OP_R);
      isBeq = (o == OP_BEQ);
      isMem = isLw || isSw;
      ill   = !(isLw || isSw || isR || isBeq);
      lat   = ill ? 2 : isLw ? 5 : (isSw || isR) ? 4 : 3;
      lat   = lat + sf + (isMem ? sm : 0);
      e.ill   = ill;
      e.lat   = lat;
      e.pcWr  = 1 + ((isBeq && z) ? 1 : 0);
      e.regWr = (isLw || isR) ? 1 : 0;
      e.memWr = isSw ? 1 + sm : 0;
      e.br    = isBeq ? 1 : 0;
      e.regRs = isLw ? 2'b01 : 2'b00;
      e.brAlu = isBeq ? 2'b01 : 2'b00;
      e.imm   = isSw ? 2'b01 : isBeq ? 2'b10 : 2'b00;
      e.ret32 = m32;
      e.ret4  = m4;
      q.push_back(e);
      if (!ill) begin
         m32 = m32 + 1;
         m4  = m4 + 1'b1;
      end
      for (int c = 0; c < lat; c++) begin
         if (c < sf)
            memReady = 1'b0;
         else if (isMem && c >= sf + 3 && c < sf + 3 + sm)
            memReady = 1'b0;
         else
            memReady = 1'b1;
         if (noise && c != sf + 1 && c != sf + 2 && c != lat - 1)
            op = 7'b1111111;
         else
            op = o;
         zero = z;
         @(posedge clk);
         #1;
      end
   endtask

   int   cyc;
   int   aPc;
   int   aReg;
   int   aMem;
   int   aBr;
   logic [1:0] aRegRs;
   logic [1:0] aBrAlu;

   task automatic clearAcc();
      cyc    = 0;
      aPc    = 0;
      aReg   = 0;
      aMem   = 0;
      aBr    = 0;
      aRegRs = 2'b00;
      aBrAlu = 2'b00;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         clearAcc();
      end else begin
         cyc++;
         if (bus32.PCWrite) aPc++;
         if (bus32.RegWrite) begin
            aReg++;
            aRegRs = bus32.ResultSrc;
         end
         if (bus32.MemWrite) aMem++;
         if (bus32.Branch) begin
            aBr++;
            aBrAlu = bus32.ALUOp;
         end
         if (bus32.instr_done || bus32.illegal) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse got 1 want 0");
            end else begin
               e = q.pop_front();
               chk("illegal", int'(bus32.illegal), int'(e.ill));
               chk("instr_done", int'(bus32.instr_done), int'(!e.ill));
               chk("latency", cyc, e.lat);
               chk("pcwrite_cycles", aPc, e.pcWr);
               chk("regwrite_cycles", aReg, e.regWr);
               chk("memwrite_cycles", aMem, e.memWr);
               chk("branch_cycles", aBr, e.br);
               chk("regwrite_resultsrc", int'(aRegRs), int'(e.regRs));
               chk("branch_aluop", int'(aBrAlu), int'(e.brAlu));
               chk("immsrc", int'(bus32.ImmSrc), int'(e.imm));
               chk("retired32", int'(bus32.retired), int'(e.ret32));
               chk("retired4", int'(bus4.retired), int'(e.ret4));
            end
            clearAcc();
         end else if (cyc > 64) begin
            checks++;
            errors++;
            $display("FAIL watchdog got %0d want <=64", cyc);
            clearAcc();
         end
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      m32      = '0;
      m4       = '0;
      rst      = 1'b1;
      op       = OP_R;
      zero     = 1'b0;
      memReady = 1'b1;
      clearAcc();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", int'(dut32.state), int'(FETCH));
      chk("rst_pcwrite", int'(bus32.PCWrite), 0);
      chk("rst_irwrite", int'(bus32.IRWrite), 0);
      chk("rst_memwrite", int'(bus32.MemWrite), 0);
      chk("rst_regwrite", int'(bus32.RegWrite), 0);
      chk("rst_done", int'(bus32.instr_done), 0);
      chk("rst_illegal", int'(bus32.illegal), 0);
      chk("rst_retired", int'(bus32.retired), 0);
      rst = 1'b0;

      issue(OP_LW, 1'b0, 0, 0, 1'b0);
      issue(OP_SW, 1'b0, 0, 3, 1'b0);
      issue(OP_BEQ, 1'b1, 0, 0, 1'b0);
      issue(OP_BEQ, 1'b0, 0, 0, 1'b0);
      issue(7'b0010011, 1'b0, 0, 0, 1'b0);
      issue(OP_R, 1'b1, 2, 0, 1'b0);
      issue(OP_LW, 1'b1, 1, 2, 1'b1);
      issue(OP_R, 1'b0, 0, 0, 1'b1);
      issue(OP_SW, 1'b0, 0, 0, 1'b0);

      // abort a store stalled in MEMWRITE
      op       = OP_SW;
      zero     = 1'b0;
      memReady = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      memReady = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mw_before_rst", int'(bus32.MemWrite), 1);
      #2;
      memReady = 1'b1;
      rst      = 1'b1;
      #1;
      chk("mw_abort", int'(bus32.MemWrite), 0);
      chk("mw_abort_pcwrite", int'(bus32.PCWrite), 0);
      chk("mw_abort_irwrite", int'(bus32.IRWrite), 0);
      chk("mw_abort_state", int'(dut32.state), int'(FETCH));
      chk("mw_abort_retired", int'(bus32.retired), 0);
      chk("mw_abort_retired4", int'(bus4.retired), 0);
      m32 = '0;
      m4  = '0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 17; i++)
         issue(OP_R, 1'b0, 0, 0, 1'b0);

      memReady = 1'b0;
      @(negedge clk);
      chk("wrap_retired4", int'(bus4.retired), int'(m4));
      chk("final_retired32", int'(bus32.retired), int'(m32));
      chk("queue_empty", q.size(), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
